// File: rtl/aes128_pipe_encrypt.sv
// Fully pipelined AES-128 encryption core.
// Accepts one (state, key) pair per clock. Round keys are expanded in step
// with the data, so every block carries its own key schedule. A pair captured
// at rising edge N appears on out after edge N+20.
// Each round spends two register banks:
//   bank A: SubBytes/ShiftRows(/MixColumns) and the next round key
//   bank B: AddRoundKey
// This keeps each stage to one lookup plus a little XOR logic.

// FIPS-197 forward S-box as a 256-entry combinational table (one per byte lane).
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[a];

endmodule

module aes128_pipe_encrypt (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic [127:0] out
);

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r rotates left by r columns; byte index is 4*col + row.
  function automatic logic [127:0] shift_rows(input logic [127:0] din);
    logic [127:0] dout;
    dout = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        dout[127 - 8*(4*c + r) -: 8] = din[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return dout;
  endfunction

  // Column-wise multiply by the circulant {02,03,01,01}.
  function automatic logic [127:0] mix_columns(input logic [127:0] din);
    logic [127:0] dout;
    logic [7:0]   a0, a1, a2, a3;
    dout = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = din[127 - 32*c -: 8];
      a1 = din[119 - 32*c -: 8];
      a2 = din[111 - 32*c -: 8];
      a3 = din[103 - 32*c -: 8];
      dout[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      dout[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      dout[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      dout[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return dout;
  endfunction

  // s_q[r]: state after round r's AddRoundKey; k_q[r]: round key r riding along.
  // t_q/kr_q: mid-round bank holding the transformed state and next round key.
  logic [127:0] s_q  [0:10];
  logic [127:0] k_q  [0:9];
  logic [127:0] t_q  [1:10];
  logic [127:0] kr_q [1:10];
  logic [127:0] t_d  [1:10];
  logic [127:0] kr_d [1:10];

  for (genvar r = 1; r <= 10; r++) begin : g_round
    logic [127:0] sb;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rw, sw;
    logic [31:0]  n0, n1, n2, n3;

    for (genvar i = 0; i < 16; i++) begin : g_lane
      aes_sbox u_sbox (
        .a (s_q[r-1][127 - 8*i -: 8]),
        .y (sb[127 - 8*i -: 8])
      );
    end

    assign {w0, w1, w2, w3} = k_q[r-1];
    assign rw = {w3[23:0], w3[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_key_lane
      aes_sbox u_sbox (
        .a (rw[31 - 8*j -: 8]),
        .y (sw[31 - 8*j -: 8])
      );
    end

    assign n0 = w0 ^ sw ^ {RCON[r], 24'h000000};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign kr_d[r] = {n0, n1, n2, n3};

    if (r == 10) begin : g_final
      assign t_d[r] = shift_rows(sb);
    end else begin : g_mid
      assign t_d[r] = mix_columns(shift_rows(sb));
    end
  end

  // Advance every pipeline bank one step; reset wipes all in-flight blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= 10; i++) s_q[i] <= '0;
      for (int i = 0; i <= 9; i++)  k_q[i] <= '0;
      for (int i = 1; i <= 10; i++) begin
        t_q[i]  <= '0;
        kr_q[i] <= '0;
      end
    end else begin
      s_q[0] <= state ^ key;
      k_q[0] <= key;
      for (int i = 1; i <= 10; i++) begin
        t_q[i]  <= t_d[i];
        kr_q[i] <= kr_d[i];
        s_q[i]  <= t_q[i] ^ kr_q[i];
      end
      for (int i = 1; i <= 9; i++) k_q[i] <= kr_q[i];
    end
  end

  assign out = s_q[10];

endmodule

// File: tb/tb_aes128_pipe_encrypt.sv
// Self-checking bench for aes128_pipe_encrypt: known FIPS-197 vectors,
// latency placement, cold and mid-stream reset, and a randomized stream
// compared against a word/matrix-level AES-128 model whose S-box is derived
// from the GF(2^8) inverse and affine map.
module tb_aes128_pipe_encrypt;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] st;
  logic [127:0] ky;
  logic [127:0] dout;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_q [$];
  string        tag_q [$];

  localparam logic [127:0] CT_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic [127:0] vpt [5] = '{128'h3243f6a8885a308d313198a2e0370734,
                            128'h00112233445566778899aabbccddeeff,
                            128'h0, 128'h0, 128'h1};
  logic [127:0] vky [5] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                            128'h000102030405060708090a0b0c0d0e0f,
                            128'h0, 128'h1, 128'h0};
  logic [127:0] vct [5] = '{128'h3925841d02dc09fbdc118597196a0b32,
                            128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                            128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                            128'h0545aad56da2a97c3663d1432a3d1c84,
                            128'h58e2fccefa7e3061367f1d57a4e7455a};

  aes128_pipe_encrypt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .state (st),
    .key   (ky),
    .out   (dout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from first principles: multiplicative inverse then affine transform.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]}
              ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ w[c][31 - 8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = sbox_m[s[(r)][(c + r) % 4]];
      s = t;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[0][c]; a1 = s[1][c]; a2 = s[2][c]; a3 = s[3][c];
          s[0][c] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[1][c] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[2][c] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[3][c] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = s[r][c] ^ w[4*rnd + c][31 - 8*r -: 8];
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127 - 8*(4*c + r) -: 8] = s[r][c];
    return res;
  endfunction

  // Drive one pair, let it be captured, then check whatever is due 20 edges later.
  task automatic step(input logic [127:0] pt, input logic [127:0] k,
                      input logic [127:0] e, input string tag);
    logic [127:0] want;
    string        wtag;
    st = pt;
    ky = k;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (exp_q.size() > 20) begin
      want = exp_q.pop_front();
      wtag = tag_q.pop_front();
      check_val(wtag, dout, want);
    end
  endtask

  initial begin
    logic [127:0] pt, k;
    logic         hit;

    build_sbox();
    check_val("model_fips_b", aes_ref(vpt[0], vky[0]), vct[0]);

    // Cold reset with random inputs toggling.
    rst_n = 1'b1;
    st = {$urandom, $urandom, $urandom, $urandom};
    ky = {$urandom, $urandom, $urandom, $urandom};
    #2 rst_n = 1'b0;
    #1 check_val("rst_immediate", dout, 128'h0);
    for (int i = 0; i < 3; i++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      ky = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      check_val($sformatf("rst_hold%0d", i), dout, 128'h0);
    end
    rst_n = 1'b1;
    exp_q.delete();
    tag_q.delete();

    // Zero flush after reset.
    for (int i = 0; i < 21; i++) step(128'h0, 128'h0, CT_ZERO, $sformatf("zero%0d", i));

    // Latency exactness: one vector between zeros.
    step(vpt[0], vky[0], vct[0], "lat_vec");
    for (int i = 0; i < 22; i++) step(128'h0, 128'h0, CT_ZERO, $sformatf("lat_zero%0d", i));

    // Back-to-back known vectors.
    for (int i = 0; i < 5; i++) step(vpt[i], vky[i], vct[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 20; i++) step(128'h0, 128'h0, CT_ZERO, $sformatf("vec_flush%0d", i));

    // Mid-stream reset: vectors in flight, then a half-cycle reset pulse.
    for (int i = 0; i < 5; i++) step(vpt[i], vky[i], vct[i], $sformatf("mid_vec%0d", i));
    for (int i = 0; i < 3; i++) step(128'h0, 128'h0, CT_ZERO, $sformatf("mid_zero%0d", i));
    rst_n = 1'b0;
    #1 check_val("mid_rst_immediate", dout, 128'h0);
    #3 check_val("mid_rst_hold", dout, 128'h0);
    #1 rst_n = 1'b1;
    exp_q.delete();
    tag_q.delete();
    for (int i = 0; i < 24; i++) begin
      step(128'h0, 128'h0, CT_ZERO, $sformatf("post_rst%0d", i));
      hit = (dout === vct[0]) || (dout === vct[1]) || (dout === vct[3]) || (dout === vct[4]);
      check_val($sformatf("no_stale%0d", i), {127'h0, hit}, 128'h0);
    end

    // Randomized full-rate stream against the reference model.
    for (int i = 0; i < 1000; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      step(pt, k, aes_ref(pt, k), $sformatf("rand%0d", i));
    end
    for (int i = 0; i < 20; i++) step(128'h0, 128'h0, CT_ZERO, $sformatf("rand_flush%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
